vischain_accum: RTL and testbench
=================================

Name: vischain_accum

Overview:
- Parametrised successor stage for correlator chains.
- Captures LENGTH parallel signed partial-visibility pairs (real/imag) in one strobe, then serialises them at one entry per cycle.
- Accumulates each entry over a runtime-selectable number of frames (1..COUNT).
- Emits finished visibilities through a small valid/ready output FIFO with first/last framing and sticky error flags.
- Sits between a bank of correlator units and the visibility readout/bus logic.

Parameters:
- LENGTH, 3, number of parallel partial sums per strobe (accumulator bins); >=1
- ADDER, 4, signed two's-complement width of each input partial
- COUNT, 5, maximum frames accumulated per result; >=1
- CBITS, $clog2(COUNT+1), width of cfg_count_i
- ACCUM, ADDER+$clog2(COUNT), signed accumulator/output width (localparam)
- OBUF, 4, output FIFO depth; power of two, >=2

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_count_i  in  CBITS  frames per result; sampled at block start
- par_valid_i  in  1  strobe: par_*_i hold LENGTH valid partials this cycle
- par_real_i  in  LENGTH*ADDER  real partials; entry k at [ADDER*(k+1)-1:ADDER*k]
- par_imag_i  in  LENGTH*ADDER  imaginary partials, same packing
- par_busy_o  in/out: out  1  serialiser busy; a strobe now is an overrun unless on final step
- vis_valid_o  out  1  output word valid
- vis_ready_i  in  1  downstream accept
- vis_first_o  out  1  output word is entry 0
- vis_last_o  out  1  output word is entry LENGTH-1
- vis_real_o  out  ACCUM  accumulated real
- vis_imag_o  out  ACCUM  accumulated imaginary
- overrun_o  out  1  sticky: strobe arrived while serialiser busy
- overflow_o  out  1  sticky: result dropped because FIFO full

Behaviour:
- Reset (synchronous, active-high) sets the following to 0: all accumulator bins, pass counter, entry index, busy, FIFO pointers/level, every output (vis_*, par_busy_o, overrun_o, overflow_o). A reset mid-block discards all partial sums and queued results.
- Capture: when par_valid_i=1 and serialiser idle (or on its final step, idx=LENGTH-1), load the partials into the shadow register, set idx=0, assert busy.
- Back-to-back strobes every LENGTH cycles are legal and lossless.
- Overrun: par_valid_i=1 while busy and idx!=LENGTH-1 → strobe ignored, overrun_o set until reset.
- Serialise: each busy cycle processes entry idx. Processing order: input signal sum = sign-extend(partial) + bin[idx]; idx increments. Busy clears after idx=LENGTH-1 unless re-captured the same cycle.
- Pass count:
  - cfg_count_i is sampled when a capture starts with pass=0 into a latched N.
  - 0 is treated as 1; values >COUNT are clamped to COUNT.
  - pass increments after idx=LENGTH-1 and wraps to 0 when pass=N-1.
- Writeback:
  - pass<N-1: bin[idx] ← sum.
  - pass=N-1: push {sum_re, sum_im, first=(idx==0), last=(idx==LENGTH-1)} into FIFO and set bin[idx] ← 0.
- Arithmetic: ACCUM is sized so that N*(-2^(ADDER-1)) through N*(2^(ADDER-1)-1) never wraps; no saturation logic.
- Latency: strobe at cycle t → entry k summed in cycle t+1+k. On the final pass, entry k is visible on vis_* from cycle t+2+k if the FIFO was empty and vis_ready_i=1.
- FIFO:
  - first-word-fall-through; vis_* registered; transfer occurs when vis_valid_o & vis_ready_i.
  - vis_* hold stable while valid and not ready.
  - Simultaneous push and pop while full: pop frees the slot, push accepted, no drop.
  - Push while full without a pop → word dropped, overflow_o set.
  - Push into an empty FIFO with pop in the same cycle: the word appears the next cycle.
- vis_real_o/vis_imag_o/first/last are 0 whenever vis_valid_o=0.
- LENGTH=1: every output word has first=last=1.

Optional Feature:
- Macro: VISCHAIN_ACCUM_DROPCNT_EN.
- When defined: adds output port drop_count_o [15:0]. It counts results dropped on FIFO-full pushes, saturates at 16'hFFFF, is cleared by reset, and overflow_o still behaves as specified.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic: LENGTH=3, cfg_count_i=1, one strobe with real={3,-2,1}, imag={0,7,-8}, vis_ready_i=1 → three words {3,0,first},{-2,7},{1,-8,last} on cycles t+2..t+4; bins read 0 afterwards.
- Accumulate: cfg_count_i=5, five strobes spaced 3 cycles apart, all partials real=-8, imag=7 → after the fifth strobe, three words real=-40, imag=35 (ACCUM=7 bits); no output earlier.
- Clamp/zero: cfg_count_i=0 → result after 1 strobe. cfg_count_i=7 with COUNT=5 → result after 5 strobes. Changing cfg_count_i mid-block has no effect until the next block.
- Overrun: strobe at t, second strobe at t+1 → second ignored, overrun_o=1 from t+2. A strobe at t+3 (final-step) is accepted, overrun_o stays 1 until reset.
- Backpressure: OBUF=4, vis_ready_i=0, cfg_count_i=1, two strobes (6 words) → 4 queued, 2 dropped, overflow_o=1, drop_count_o=2 (if enabled). Raising ready drains the 4 words in order.
- Reset mid-block: cfg_count_i=3, two strobes, assert reset one cycle, then three strobes → outputs equal the sum of the last three only; all flags 0 right after reset.

Source files
------------

// File: rtl/vischain_accum_if.sv
// Bundles the partial-sum input, visibility output and status signals of vischain_accum.
interface vischain_accum_if #(
  parameter int LENGTH = 3,
  parameter int ADDER  = 4,
  parameter int COUNT  = 5
);
  localparam int CBITS = $clog2(COUNT + 1);
  localparam int ACCUM = ADDER + $clog2(COUNT);

  logic [CBITS-1:0]          cfg_count_i;
  logic                      par_valid_i;
  logic [LENGTH*ADDER-1:0]   par_real_i;
  logic [LENGTH*ADDER-1:0]   par_imag_i;
  logic                      par_busy_o;
  logic                      vis_valid_o;
  logic                      vis_ready_i;
  logic                      vis_first_o;
  logic                      vis_last_o;
  logic signed [ACCUM-1:0]   vis_real_o;
  logic signed [ACCUM-1:0]   vis_imag_o;
  logic                      overrun_o;
  logic                      overflow_o;

  modport master (
    output cfg_count_i, par_valid_i, par_real_i, par_imag_i, vis_ready_i,
    input  par_busy_o, vis_valid_o, vis_first_o, vis_last_o, vis_real_o, vis_imag_o,
           overrun_o, overflow_o
  );

  modport slave (
    input  cfg_count_i, par_valid_i, par_real_i, par_imag_i, vis_ready_i,
    output par_busy_o, vis_valid_o, vis_first_o, vis_last_o, vis_real_o, vis_imag_o,
           overrun_o, overflow_o
  );
endinterface

// File: rtl/vischain_accum.sv
// Serialising multi-frame visibility accumulator with a FWFT output FIFO.
// Optional VISCHAIN_ACCUM_DROPCNT_EN adds a saturating dropped-result counter.
module vischain_accum #(
  parameter int LENGTH = 3,
  parameter int ADDER  = 4,
  parameter int COUNT  = 5,
  parameter int CBITS  = $clog2(COUNT + 1),
  parameter int OBUF   = 4
) (
  input  logic            clock,
  input  logic            reset,
  vischain_accum_if.slave bus
`ifdef VISCHAIN_ACCUM_DROPCNT_EN
  , output logic [15:0]   drop_count_o
`endif
);
  localparam int ACCUM = ADDER + $clog2(COUNT);
  localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int PW    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int AW    = $clog2(OBUF);
  localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

  logic signed [ADDER-1:0] shad_re [LENGTH];
  logic signed [ADDER-1:0] shad_im [LENGTH];
  logic signed [ACCUM-1:0] bin_re  [LENGTH];
  logic signed [ACCUM-1:0] bin_im  [LENGTH];
  logic [IW-1:0]           idx;
  logic                    busy;
  logic [PW-1:0]           pass;
  logic [PW-1:0]           n_last;
  logic                    overrun;

  logic signed [ACCUM-1:0] mem_re [OBUF];
  logic signed [ACCUM-1:0] mem_im [OBUF];
  logic                    mem_first [OBUF];
  logic                    mem_last  [OBUF];
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [AW:0]             level;

  logic                    final_step;
  logic                    capture;
  logic                    push_req;
  logic                    push_ok;
  logic                    pop;
  logic                    drop;
  logic [PW-1:0]           pass_after;
  logic [CBITS-1:0]        cfg_m1;
  logic signed [ACCUM-1:0] sum_re;
  logic signed [ACCUM-1:0] sum_im;
  logic [AW-1:0]           rd_next;
  logic [AW:0]             remain;
  logic [AW:0]             level_next;

  // Control decode: capture/overrun, pass advance, FIFO push/pop bookkeeping.
  always_comb begin
    final_step = busy && (idx == LAST);
    capture    = bus.par_valid_i && (!busy || final_step);
    push_req   = busy && (pass == n_last);
    if (final_step) begin
      pass_after = (pass == n_last) ? '0 : pass + PW'(1);
    end else begin
      pass_after = pass;
    end
    if (bus.cfg_count_i == '0) begin
      cfg_m1 = '0;
    end else if (bus.cfg_count_i > CBITS'(COUNT)) begin
      cfg_m1 = CBITS'(COUNT - 1);
    end else begin
      cfg_m1 = bus.cfg_count_i - CBITS'(1);
    end
    sum_re     = ACCUM'(shad_re[idx]) + bin_re[idx];
    sum_im     = ACCUM'(shad_im[idx]) + bin_im[idx];
    pop        = bus.vis_valid_o && bus.vis_ready_i;
    push_ok    = push_req && ((level != (AW+1)'(OBUF)) || pop);
    drop       = push_req && !push_ok;
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    remain     = pop ? level - (AW+1)'(1) : level;
    level_next = push_ok ? remain + (AW+1)'(1) : remain;
  end

  // Shadow capture, serialiser and per-bin accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LENGTH; k++) begin
        shad_re[k] <= '0;
        shad_im[k] <= '0;
        bin_re[k]  <= '0;
        bin_im[k]  <= '0;
      end
      idx     <= '0;
      busy    <= 1'b0;
      pass    <= '0;
      n_last  <= '0;
      overrun <= 1'b0;
    end else begin
      if (bus.par_valid_i && busy && !final_step) begin
        overrun <= 1'b1;
      end
      if (capture) begin
        for (int k = 0; k < LENGTH; k++) begin
          shad_re[k] <= bus.par_real_i[ADDER*k +: ADDER];
          shad_im[k] <= bus.par_imag_i[ADDER*k +: ADDER];
        end
        // A block boundary is the pass value the new strobe will see.
        if (pass_after == '0) begin
          n_last <= cfg_m1[PW-1:0];
        end
      end
      if (busy) begin
        bin_re[idx] <= push_req ? '0 : sum_re;
        bin_im[idx] <= push_req ? '0 : sum_im;
      end
      pass <= pass_after;
      if (capture) begin
        idx  <= '0;
        busy <= 1'b1;
      end else if (final_step) begin
        idx  <= '0;
        busy <= 1'b0;
      end else if (busy) begin
        idx  <= idx + IW'(1);
      end
    end
  end

  // FIFO storage; queued words are discarded by resetting the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_re[wr_ptr]    <= sum_re;
      mem_im[wr_ptr]    <= sum_im;
      mem_first[wr_ptr] <= (idx == '0);
      mem_last[wr_ptr]  <= final_step;
    end
  end

  // FIFO pointers and registered head word (first-word-fall-through).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      level           <= '0;
      bus.vis_valid_o <= 1'b0;
      bus.vis_real_o  <= '0;
      bus.vis_imag_o  <= '0;
      bus.vis_first_o <= 1'b0;
      bus.vis_last_o  <= 1'b0;
      bus.overflow_o  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (drop) begin
        bus.overflow_o <= 1'b1;
      end
      rd_ptr <= rd_next;
      level  <= level_next;
      if (remain != '0) begin
        bus.vis_valid_o <= 1'b1;
        bus.vis_real_o  <= mem_re[rd_next];
        bus.vis_imag_o  <= mem_im[rd_next];
        bus.vis_first_o <= mem_first[rd_next];
        bus.vis_last_o  <= mem_last[rd_next];
      end else if (push_ok) begin
        bus.vis_valid_o <= 1'b1;
        bus.vis_real_o  <= sum_re;
        bus.vis_imag_o  <= sum_im;
        bus.vis_first_o <= (idx == '0);
        bus.vis_last_o  <= final_step;
      end else begin
        bus.vis_valid_o <= 1'b0;
        bus.vis_real_o  <= '0;
        bus.vis_imag_o  <= '0;
        bus.vis_first_o <= 1'b0;
        bus.vis_last_o  <= 1'b0;
      end
    end
  end

`ifdef VISCHAIN_ACCUM_DROPCNT_EN
  // Saturating count of results lost to a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_o <= 16'h0000;
    end else if (drop && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'h0001;
    end
  end
`endif

  assign bus.par_busy_o = busy;
  assign bus.overrun_o  = overrun;
endmodule

// File: tb/tb_vischain_accum.sv
// Directed bench for vischain_accum: frame-level reference model plus literal spot checks.
module tb_vischain_accum;
  localparam int L  = 3;
  localparam int A  = 4;
  localparam int C  = 5;
  localparam int OB = 4;
  localparam int LA = L * A;

  typedef struct {
    longint re;
    longint im;
    bit     first;
    bit     last;
  } word_t;

  logic clock = 1'b0;
  logic reset;
`ifdef VISCHAIN_ACCUM_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  vischain_accum_if #(.LENGTH(L), .ADDER(A), .COUNT(C)) bus ();

  vischain_accum #(.LENGTH(L), .ADDER(A), .COUNT(C), .OBUF(OB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef VISCHAIN_ACCUM_DROPCNT_EN
    , .drop_count_o (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  word_t  exp_q[$];
  word_t  pend_q[$];
  longint acc_re [L];
  longint acc_im [L];
  int     gap = L;
  int     blk_cnt = 0;
  int     blk_n = 1;
  bit     m_overrun = 1'b0;
  bit     m_overflow = 1'b0;
  int     m_drops = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint part(input logic [LA-1:0] v, input int k);
    logic signed [A-1:0] p;
    p = v[A*k +: A];
    return longint'(p);
  endfunction

  // Reference model: strobes accepted at most once per L cycles, N-frame sums per entry.
  initial forever begin
    word_t w;
    int n;
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      for (int k = 0; k < L; k++) begin
        acc_re[k] = 0;
        acc_im[k] = 0;
      end
      gap = L; blk_cnt = 0; m_overrun = 1'b0; m_overflow = 1'b0; m_drops = 0;
    end else begin
      if (exp_q.size() > 0 && bus.vis_ready_i) void'(exp_q.pop_front());
      if (pend_q.size() > 0) begin
        w = pend_q.pop_front();
        if (exp_q.size() < OB) exp_q.push_back(w);
        else begin
          m_overflow = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (gap < 1000) gap++;
      if (bus.par_valid_i) begin
        if (gap >= L) begin
          gap = 0;
          if (blk_cnt == 0) begin
            n = int'(bus.cfg_count_i);
            blk_n = (n == 0) ? 1 : ((n > C) ? C : n);
          end
          for (int k = 0; k < L; k++) begin
            acc_re[k] += part(bus.par_real_i, k);
            acc_im[k] += part(bus.par_imag_i, k);
          end
          blk_cnt++;
          if (blk_cnt == blk_n) begin
            for (int k = 0; k < L; k++) begin
              w.re = acc_re[k]; w.im = acc_im[k];
              w.first = (k == 0); w.last = (k == L - 1);
              pend_q.push_back(w);
              acc_re[k] = 0; acc_im[k] = 0;
            end
            blk_cnt = 0;
          end
        end else begin
          m_overrun = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("vis_valid", bus.vis_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("vis_real", bus.vis_real_o, exp_q[0].re);
        check("vis_imag", bus.vis_imag_o, exp_q[0].im);
        check("vis_first", bus.vis_first_o, exp_q[0].first);
        check("vis_last", bus.vis_last_o, exp_q[0].last);
      end else begin
        check("vis_idle_zero", {bus.vis_real_o, bus.vis_imag_o, bus.vis_first_o, bus.vis_last_o}, 0);
      end
      check("par_busy", bus.par_busy_o, gap < L);
      check("overrun", bus.overrun_o, m_overrun);
      check("overflow", bus.overflow_o, m_overflow);
`ifdef VISCHAIN_ACCUM_DROPCNT_EN
      check("drop_count", drop_count, m_drops);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [LA-1:0] re, input logic [LA-1:0] im);
    bus.par_valid_i = 1'b1;
    bus.par_real_i  = re;
    bus.par_imag_i  = im;
    tick();
    bus.par_valid_i = 1'b0;
  endtask

  task automatic lit(input string name, input longint re, input longint im, input bit first, input bit last);
    check({name, "_valid"}, bus.vis_valid_o, 1);
    check({name, "_re"}, bus.vis_real_o, re);
    check({name, "_im"}, bus.vis_imag_o, im);
    check({name, "_first"}, bus.vis_first_o, first);
    check({name, "_last"}, bus.vis_last_o, last);
  endtask

  initial begin
    reset = 1'b1;
    bus.par_valid_i = 1'b0;
    bus.par_real_i  = '0;
    bus.par_imag_i  = '0;
    bus.cfg_count_i = 3'd1;
    bus.vis_ready_i = 1'b1;
    idle(2);
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", bus.vis_valid_o, 0);
    check("rst_busy", bus.par_busy_o, 0);
    check("rst_overrun", bus.overrun_o, 0);
    check("rst_overflow", bus.overflow_o, 0);
    tick();

    // Basic: real {3,-2,1}, imag {0,7,-8}
    bus.cfg_count_i = 3'd1;
    strobe({4'h1, 4'hE, 4'h3}, {4'h8, 4'h7, 4'h0});
    @(negedge clock);
    @(negedge clock); lit("basic0", 3, 0, 1'b1, 1'b0);
    @(negedge clock); lit("basic1", -2, 7, 1'b0, 1'b0);
    @(negedge clock); lit("basic2", 1, -8, 1'b0, 1'b1);
    tick(); idle(3);

    // Five frames of -8/+7 → -40/35
    bus.cfg_count_i = 3'd5;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("acc_no_early", bus.vis_valid_o, 0);
      strobe({3{4'h8}}, {3{4'h7}});
      if (i < 4) idle(2);
    end
    @(negedge clock);
    @(negedge clock); lit("acc0", -40, 35, 1'b1, 1'b0);
    tick(); idle(6);

    // Zero count behaves as one frame
    bus.cfg_count_i = 3'd0;
    strobe({4'h1, 4'h2, 4'h3}, {3{4'hF}});
    @(negedge clock);
    @(negedge clock); lit("zero0", 3, -1, 1'b1, 1'b0);
    tick(); idle(5);

    // Count 7 clamps to 5; mid-block change ignored
    bus.cfg_count_i = 3'd7;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("clamp_no_early", bus.vis_valid_o, 0);
      strobe({4'h1, 4'h2, 4'h3}, {3{4'hF}});
      bus.cfg_count_i = 3'd1;
      if (i < 4) idle(2);
    end
    @(negedge clock);
    @(negedge clock); lit("clamp0", 15, -5, 1'b1, 1'b0);
    tick(); idle(6);

    // Backpressure: 6 words into a 4-deep FIFO
    bus.vis_ready_i = 1'b0;
    bus.cfg_count_i = 3'd1;
    strobe({4'h3, 4'h2, 4'h1}, 12'h000);
    idle(2);
    strobe({4'h6, 4'h5, 4'h4}, 12'h000);
    idle(5);
    check("bp_overflow", bus.overflow_o, 1);
    lit("bp_head", 1, 0, 1'b1, 1'b0);
`ifdef VISCHAIN_ACCUM_DROPCNT_EN
    check("bp_drops", drop_count, 2);
`endif
    bus.vis_ready_i = 1'b1;
    idle(6);

    // Reset mid-block discards partial sums and clears flags
    bus.cfg_count_i = 3'd3;
    strobe({3{4'h7}}, {3{4'h7}});
    idle(2);
    strobe({3{4'h7}}, {3{4'h7}});
    idle(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_overflow", bus.overflow_o, 0);
    check("mid_rst_overrun", bus.overrun_o, 0);
    check("mid_rst_valid", bus.vis_valid_o, 0);
    check("mid_rst_busy", bus.par_busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      strobe({3{4'h1}}, {3{4'h2}});
      if (i < 2) idle(2);
    end
    @(negedge clock);
    @(negedge clock); lit("mid0", 3, 6, 1'b1, 1'b0);
    tick(); idle(6);

    // Overrun: strobe at t+1 ignored, strobe at t+3 accepted
    bus.cfg_count_i = 3'd1;
    strobe({4'h1, 4'h1, 4'h5}, {4'h2, 4'h2, 4'h6});
    strobe({3{4'h7}}, {3{4'h7}});
    check("ovr_set", bus.overrun_o, 1);
    @(negedge clock); lit("ovr0", 5, 6, 1'b1, 1'b0);
    tick();
    strobe({4'h9, 4'h9, 4'hC}, {4'h1, 4'h1, 4'h3});
    idle(8);
    check("ovr_sticky", bus.overrun_o, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
